// File: rtl/spi_flash_read_sequencer.sv
// SPI NOR READ (0x03) sequencer: drives the byte engine through command, 24-bit address and N data bytes.
// Owns flash_cs_n across the whole transaction and streams received bytes out with valid/ready.
module spi_flash_read_sequencer #(
    parameter logic [7:0] READ_CMD      = 8'h03,
    parameter int         LEN_WIDTH     = 16,
    parameter int         CS_GAP_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic [23:0]          req_addr,
    input  logic [LEN_WIDTH-1:0] req_len,
    output logic                 req_ready,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 done,
    output logic                 flash_cs_n,
    output logic                 spi_start,
    output logic [7:0]           spi_data_in,
    input  logic                 spi_busy,
    input  logic [7:0]           spi_data_out
);
    localparam int            TW         = $clog2(CS_GAP_CYCLES + 1) + 1;
    localparam logic [TW-1:0] SETUP_LAST = TW'(CS_GAP_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(CS_GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_DELIVER, S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [23:0]          addr_q, addr_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [2:0]           idx_q, idx_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [7:0]           rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 done_q, done_d;
    logic                 cs_n_q, cs_n_d;
    logic                 start_q, start_d;
    logic [7:0]           din_q, din_d;

    function automatic logic [7:0] sched_byte(input logic [2:0] idx, input logic [23:0] addr);
        case (idx)
            3'd0:    return READ_CMD;
            3'd1:    return addr[23:16];
            3'd2:    return addr[15:8];
            3'd3:    return addr[7:0];
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        done_d      = 1'b0;
        cs_n_d      = cs_n_q;
        start_d     = start_q;
        din_d       = din_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d      = req_addr;
                    remaining_d = req_len;
                    if (req_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cs_n_d  = 1'b0;
                        timer_d = '0;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (timer_q == SETUP_LAST) begin
                    idx_d   = 3'd0;
                    start_d = 1'b1;
                    din_d   = sched_byte(3'd0, addr_q);
                    state_d = S_ISSUE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            // start is a level; the engine only samples it on its own SCK tick
            S_ISSUE: begin
                if (spi_busy) begin
                    start_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!spi_busy) begin
                    if (idx_q < 3'd4) begin
                        idx_d   = idx_q + 3'd1;
                        start_d = 1'b1;
                        din_d   = sched_byte(idx_q + 3'd1, addr_q);
                        state_d = S_ISSUE;
                    end else begin
                        rd_data_d  = spi_data_out;
                        rd_valid_d = 1'b1;
                        state_d    = S_DELIVER;
                    end
                end
            end
            S_DELIVER: begin
                if (rd_ready) begin
                    rd_valid_d  = 1'b0;
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q != LEN_WIDTH'(1)) begin
                        start_d = 1'b1;
                        din_d   = 8'h00;
                        state_d = S_ISSUE;
                    end else begin
                        cs_n_d  = 1'b1;
                        timer_d = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            start_q     <= 1'b0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            cs_n_q      <= cs_n_d;
            start_q     <= start_d;
            din_q       <= din_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign done        = done_q;
    assign flash_cs_n  = cs_n_q;
    assign spi_start   = start_q;
    assign spi_data_in = din_q;
endmodule

// File: doc/spi_flash_read_sequencer.md
# spi_flash_read_sequencer

Sequences the SPI byte engine (`spi_master_controller`) to perform SPI NOR flash READ (0x03) transactions: command byte, 24-bit address, then N data bytes streamed out with valid/ready backpressure. Owns the flash chip-select and holds it low across the whole transaction; the byte engine's own per-byte `cs` output is left unconnected. Sits between boot/asset loaders and the SPI pins.

## Interface
- `READ_CMD`, 8'h03, opcode sent as first byte
- `LEN_WIDTH`, 16, width of byte-count request field
- `CS_GAP_CYCLES`, 4, clk cycles of CS setup (low before first byte) and CS high time after a transaction; ≥1
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `req`  in  1  transaction request
- `req_addr`  in  24  flash byte address
- `req_len`  in  LEN_WIDTH  data bytes to read; 0 allowed
- `req_ready`  out  1  high in IDLE only
- `rd_data`  out  8  received data byte
- `rd_valid`  out  1  `rd_data` valid; held until `rd_ready`
- `rd_ready`  in  1  consumer accepts byte
- `done`  out  1  one-cycle pulse at transaction end
- `flash_cs_n`  out  1  flash chip select, active-low
- `spi_start`  out  1  to byte engine `start`
- `spi_data_in`  out  8  to byte engine `data_in`
- `spi_busy`  in  1  from byte engine `busy`
- `spi_data_out`  in  8  from byte engine `data_out`
- Reset: reset reset, synchronous, active-high; clock clk.

## Operation
- States: IDLE, SETUP, ISSUE, WAIT, DELIVER, GAP. All outputs registered except `req_ready` (= state==IDLE).
- IDLE: on `req && req_ready` latch addr, len; len==0 → pulse `done` next cycle, stay IDLE, no CS/SPI activity; else `flash_cs_n`←0, timer←0, → SETUP.
- SETUP: count CS_GAP_CYCLES, then byte index←0 → ISSUE.
- Byte schedule by index: 0 = READ_CMD, 1 = addr[23:16], 2 = addr[15:8], 3 = addr[7:0], ≥4 = 8'h00 (dummy MOSI for data).
- ISSUE: drive `spi_data_in`, assert `spi_start`; hold both until `spi_busy`==1, then drop `spi_start` → WAIT.
- WAIT: on `spi_busy`==0: header byte (index<4) → index+1, ISSUE; data byte → `rd_data`←`spi_data_out`, `rd_valid`←1 → DELIVER. Header MISO data discarded.
- DELIVER: hold `rd_data`/`rd_valid` until `rd_ready`; then `rd_valid`←0, remaining−1; remaining>0 → ISSUE; else `flash_cs_n`←1, timer←0 → GAP.
- GAP: CS high for CS_GAP_CYCLES, then pulse `done`, → IDLE.
- Remaining-byte counter is LEN_WIDTH bits; max transaction 2^LEN_WIDTH−1 bytes; address not incremented internally (flash auto-increments).

## Timing
- Reset values: state IDLE, `req_ready` 1, `flash_cs_n` 1, `spi_start` 0, `spi_data_in` 0, `rd_data` 0, `rd_valid` 0, `done` 0.
- Accept → `flash_cs_n` low: 1 cycle. CS low → first `spi_start`: CS_GAP_CYCLES cycles.
- `spi_start` held level (byte engine samples only on SCK ticks); never asserted while `spi_busy` high from a previous byte.
- `spi_data_in` stable from `spi_start` rise until `spi_busy` seen high.
- `flash_cs_n` continuously low from SETUP through last DELIVER handshake; no glitch between bytes.
- `rd_valid` && `rd_ready` same cycle as entry to DELIVER: accepted that cycle edge; next byte ISSUE follows next cycle.
- `rd_ready` while `rd_valid`=0 ignored; `req` outside IDLE ignored.
- `done` asserted exactly once per accepted request, CS_GAP_CYCLES+1 cycles after `flash_cs_n` rises (1 cycle after accept for len 0).
- Reset mid-transaction: next edge all outputs to reset values, CS high, no `done`; byte engine shares reset.

## Test plan
- Read len=3 @0x012345, flash model returns A5,5A,3C → MOSI bytes 03,01,23,45,00,00,00; `rd_data` A5,5A,3C in order; `flash_cs_n` low for entire transfer; one `done`.
- len=0 request → `done` one cycle after accept; `flash_cs_n` stays 1; `spi_start` never asserted.
- Backpressure: `rd_ready` low 50 cycles on byte 1 of 2 → `rd_data` stable, `rd_valid` held, no `spi_start`, CS stays low; release → byte 2 delivered.
- Back-to-back requests (`req` held high) → CS high ≥CS_GAP_CYCLES between transactions; second `req` accepted only when `req_ready`=1.
- Reset asserted during byte 2 of data phase → next cycle `flash_cs_n`=1, `rd_valid`=0, `req_ready`=1, no `done`; fresh request afterwards completes correctly.
- CLK_DIVIDER=4 on byte engine, len=2 → identical byte sequence/data; `spi_start` held until `spi_busy` rises.
